// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer.
// Contents:
//   DefW / DefN : default FIFO word width and words packed per output word
//   state_e     : packer FSM state (StFill while collecting, StOut while presenting)
package fifo_pkg;

   localparam int unsigned DefW = 4;
   localparam int unsigned DefN = 4;

   typedef enum logic {
      StFill,
      StOut
   } state_e;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Bus bundle between the packer, its upstream FIFO read port and the downstream consumer.
// Optional feature macro: FIFO_PACK_FLUSH_EN (adds flush and out_cnt).
// Signals:
//   fifo_empty : upstream FIFO empty flag
//   fifo_re    : FIFO read strobe (packer drives)
//   fifo_rd    : FIFO read data, valid one cycle after fifo_re
//   out_data   : packed word, first FIFO word in the LSBs
//   out_valid  : out_data valid
//   out_ready  : downstream accepts out_data when out_valid && out_ready
//   flush      : request to emit a partial word              (FIFO_PACK_FLUSH_EN)
//   out_cnt    : number of valid FIFO words held in out_data (FIFO_PACK_FLUSH_EN)
// Modports: master = packer side, slave = surrounding FIFO/consumer side.
interface fifo_rd_packer_if
   import fifo_pkg::*;
#(
   parameter int unsigned W = DefW,
   parameter int unsigned N = DefN
);

   logic             fifo_empty;
   logic             fifo_re;
   logic [W-1:0]     fifo_rd;
   logic [N*W-1:0]   out_data;
   logic             out_valid;
   logic             out_ready;

`ifdef FIFO_PACK_FLUSH_EN
   logic                   flush;
   logic [$clog2(N+1)-1:0] out_cnt;

   modport master (
      input  fifo_empty, fifo_rd, out_ready, flush,
      output fifo_re, out_data, out_valid, out_cnt
   );

   modport slave (
      output fifo_empty, fifo_rd, out_ready, flush,
      input  fifo_re, out_data, out_valid, out_cnt
   );
`else
   modport master (
      input  fifo_empty, fifo_rd, out_ready,
      output fifo_re, out_data, out_valid
   );

   modport slave (
      output fifo_empty, fifo_rd, out_ready,
      input  fifo_re, out_data, out_valid
   );
`endif

endinterface

// File: rtl/fifo_rd_packer.sv
// Reads W-bit words from a FIFO read port and packs N of them into one N*W-bit output word.
// Optional feature macro: FIFO_PACK_FLUSH_EN (flush request emits a partial word; out_cnt
// reports how many slots are valid).
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : fifo_rd_packer_if.master (FIFO read side + packed output handshake)
// W and N must match the parameters of the connected interface instance.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int unsigned W = DefW,
   parameter int unsigned N = DefN
) (
   input logic               clk,
   input logic               rst,
   fifo_rd_packer_if.master  bus
);

   localparam int unsigned CW = $clog2(N + 1);
   typedef logic [CW-1:0] cnt_t;

   state_e         state_q, state_d;
   cnt_t           cnt_q, cnt_d;
   logic           pend_q;
   logic [N*W-1:0] data_q, data_d;
   logic           valid_q, valid_d;
   logic           hs;
   logic           word_done;
   cnt_t           cnt_base;
   logic           fifo_re;
   logic           flush_q;
   logic           flush_go;

`ifdef FIFO_PACK_FLUSH_EN
   logic flush_d;
   logic flush_drop;
   cnt_t out_cnt_q, out_cnt_d;

   // A flush only acts once no read is in flight, so the partial word is complete.
   assign flush_go   = flush_q && !pend_q && (state_q == StFill) && (cnt_q != '0);
   assign flush_drop = flush_q && !pend_q && (state_q == StFill) && (cnt_q == '0);
`else
   assign flush_q  = 1'b0;
   assign flush_go = 1'b0;
`endif

   assign hs        = valid_q && bus.out_ready;
   assign word_done = (state_q == StFill) && pend_q && (cnt_q == cnt_t'(N - 1));
   // On the handshake the word is gone, so a read landing now or later starts at slot 0.
   assign cnt_base  = hs ? '0 : cnt_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFill;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFill:  if (word_done || flush_go) state_d = StOut;
         StOut:   if (hs) state_d = StFill;
         default: state_d = StFill;
      endcase
   end

   // Outputs and datapath next values
   always_comb begin
      // Never request more words than free slots, counting a read still in flight.
      fifo_re = !bus.fifo_empty && !rst && !flush_q &&
                ((32'(cnt_base) + 32'(pend_q)) < N) &&
                ((state_q == StFill) || hs);

      data_d = hs ? '0 : data_q;
      cnt_d  = cnt_base;
      if (pend_q) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (cnt_base == cnt_t'(i)) data_d[i*W +: W] = bus.fifo_rd;
         end
         cnt_d = cnt_base + cnt_t'(1);
      end

      valid_d = valid_q;
      if (hs) valid_d = 1'b0;
      if (word_done || flush_go) valid_d = 1'b1;

`ifdef FIFO_PACK_FLUSH_EN
      out_cnt_d = out_cnt_q;
      if (word_done) out_cnt_d = cnt_t'(N);
      if (flush_go) out_cnt_d = cnt_q;
      flush_d = (flush_q && !(flush_go || flush_drop)) || bus.flush;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pend_q  <= fifo_re;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

`ifdef FIFO_PACK_FLUSH_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         out_cnt_q <= '0;
         flush_q   <= 1'b0;
      end else begin
         out_cnt_q <= out_cnt_d;
         flush_q   <= flush_d;
      end
   end

   assign bus.out_cnt = out_cnt_q;
`endif

   assign bus.fifo_re   = fifo_re;
   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_q;

endmodule
